// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared types and baud divider helper for the UART transmit path
package uart_pkg;

    typedef enum logic [1:0] {
        PARITY_NONE = 2'd0,
        PARITY_ODD  = 2'd1,
        PARITY_EVEN = 2'd2
    } parity_mode_e;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP
`ifdef UART_TX_BREAK_EN
        , ST_BREAK
`endif
    } tx_state_e;

    function automatic int baud_div(input int sysclk, input int baud);
        return sysclk / baud;
    endfunction

endpackage

// File: rtl/uart_sync_fifo.sv
// rtl/uart_sync_fifo.sv - synchronous write FIFO with registered flags, level and sticky overflow
module uart_sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8,
    parameter int LW    = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] push_data,
    input  logic             push,
    input  logic             pop,
    input  logic             overflow_clr,
    output logic [WIDTH-1:0] pop_data,
    output logic             full,
    output logic             empty,
    output logic             overflow,
    output logic [LW-1:0]    level
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             accept;
    logic             drop;
    logic [LW-1:0]    level_next;

    // A pop in the same cycle frees a slot, so a push into a full FIFO still lands.
    assign accept     = push && (!full || pop);
    assign drop       = push && full && !pop;
    assign level_next = level + LW'(accept) - LW'(pop);
    assign pop_data   = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (accept) begin
            mem[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            level    <= '0;
            full     <= 1'b0;
            empty    <= 1'b1;
            overflow <= 1'b0;
        end else begin
            if (accept) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            level <= level_next;
            full  <= (level_next == LW'(DEPTH));
            empty <= (level_next == '0);
            if (drop) begin
                overflow <= 1'b1;
            end else if (overflow_clr) begin
                overflow <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/uart_tx_fifo.sv
// rtl/uart_tx_fifo.sv - buffered UART transmitter with parity, stop bits and CTS gating
// Optional line-break generation is enabled by defining UART_TX_BREAK_EN.
module uart_tx_fifo
    import uart_pkg::*;
#(
    parameter int SYSCLK_RATE = 100000000,
    parameter int BAUD_RATE   = 9600,
    parameter int DATA_BITS   = 8,
    parameter int PARITY_MODE = 2,
    parameter int STOP_BITS   = 2,
    parameter int FIFO_DEPTH  = 8
) (
    input  logic                              SysClk,
    input  logic                              Rst,
    input  logic [DATA_BITS-1:0]              Tx_Data,
    input  logic                              Write_En,
    input  logic                              Overflow_Clr,
    input  logic                              CTS,
`ifdef UART_TX_BREAK_EN
    input  logic                              Break_Req,
`endif
    output logic                              Tx,
    output logic                              Tx_Busy,
    output logic                              FIFO_Empty,
    output logic                              FIFO_Full,
    output logic                              FIFO_Overflow,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]   Fill_Level
);

    localparam int DIV        = baud_div(SYSCLK_RATE, BAUD_RATE);
    localparam int CW         = $clog2(DIV);
    localparam int BW         = $clog2(DATA_BITS + 1);
    localparam bit HAS_PARITY = (PARITY_MODE != int'(PARITY_NONE));
    localparam bit EVEN       = (PARITY_MODE == int'(PARITY_EVEN));

    tx_state_e            state;
    tx_state_e            state_next;
    logic [CW-1:0]        cnt;
    logic [CW-1:0]        cnt_next;
    logic [BW-1:0]        bit_idx;
    logic [BW-1:0]        bit_next;
    logic [DATA_BITS-1:0] shreg;
    logic [DATA_BITS-1:0] fifo_data;
    logic                 par_bit;
    logic                 cts_m;
    logic                 cts_s;
    logic                 bit_end;
    logic                 can_start;
    logic                 launch;
    logic                 pop;
`ifdef UART_TX_BREAK_EN
    logic                 break_rel;
    logic                 rel_next;
`endif

    uart_sync_fifo #(
        .WIDTH (DATA_BITS),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk          (SysClk),
        .rst          (Rst),
        .push_data    (Tx_Data),
        .push         (Write_En),
        .pop          (pop),
        .overflow_clr (Overflow_Clr),
        .pop_data     (fifo_data),
        .full         (FIFO_Full),
        .empty        (FIFO_Empty),
        .overflow     (FIFO_Overflow),
        .level        (Fill_Level)
    );

    always_ff @(posedge SysClk) begin
        if (Rst) begin
            cts_m <= 1'b0;
            cts_s <= 1'b0;
        end else begin
            cts_m <= CTS;
            cts_s <= cts_m;
        end
    end

    assign bit_end   = (cnt == CW'(DIV - 1));
    assign can_start = !FIFO_Empty && cts_s;

    always_comb begin
        state_next = state;
        cnt_next   = bit_end ? '0 : cnt + 1'b1;
        bit_next   = bit_idx;
        pop        = 1'b0;
        launch     = 1'b0;
`ifdef UART_TX_BREAK_EN
        rel_next   = break_rel;
`endif
        case (state)
            ST_IDLE: begin
                launch = 1'b1;
            end
            ST_START: begin
                if (bit_end) begin
                    state_next = ST_DATA;
                    bit_next   = '0;
                end
            end
            ST_DATA: begin
                if (bit_end) begin
                    if (bit_idx == BW'(DATA_BITS - 1)) begin
                        bit_next   = '0;
                        state_next = HAS_PARITY ? ST_PARITY : ST_STOP;
                    end else begin
                        bit_next = bit_idx + 1'b1;
                    end
                end
            end
            ST_PARITY: begin
                if (bit_end) begin
                    state_next = ST_STOP;
                    bit_next   = '0;
                end
            end
            ST_STOP: begin
                if (bit_end) begin
                    if (bit_idx == BW'(STOP_BITS - 1)) begin
                        launch = 1'b1;
                    end else begin
                        bit_next = bit_idx + 1'b1;
                    end
                end
            end
`ifdef UART_TX_BREAK_EN
            // Line held low until release, then one idle bit time before the next launch.
            ST_BREAK: begin
                if (!break_rel) begin
                    cnt_next = '0;
                    if (!Break_Req) begin
                        rel_next = 1'b1;
                    end
                end else if (bit_end) begin
                    launch = 1'b1;
                end
            end
`endif
            default: begin
                state_next = ST_IDLE;
            end
        endcase

        if (launch) begin
            cnt_next = '0;
            bit_next = '0;
`ifdef UART_TX_BREAK_EN
            rel_next = 1'b0;
            if (Break_Req) begin
                state_next = ST_BREAK;
            end else
`endif
            if (can_start) begin
                pop        = 1'b1;
                state_next = ST_START;
            end else begin
                state_next = ST_IDLE;
            end
        end
    end

    always_ff @(posedge SysClk) begin
        if (Rst) begin
            state     <= ST_IDLE;
            cnt       <= '0;
            bit_idx   <= '0;
`ifdef UART_TX_BREAK_EN
            break_rel <= 1'b0;
`endif
        end else begin
            state     <= state_next;
            cnt       <= cnt_next;
            bit_idx   <= bit_next;
`ifdef UART_TX_BREAK_EN
            break_rel <= rel_next;
`endif
        end
    end

    always_ff @(posedge SysClk) begin
        if (Rst) begin
            shreg   <= '0;
            par_bit <= 1'b0;
        end else if (pop) begin
            shreg   <= fifo_data;
            par_bit <= EVEN ? ^fifo_data : ~^fifo_data;
        end else if (state == ST_DATA && bit_end) begin
            shreg   <= shreg >> 1;
        end
    end

    // Line and busy are registered from the current state so they stay aligned.
    always_ff @(posedge SysClk) begin
        if (Rst) begin
            Tx      <= 1'b1;
            Tx_Busy <= 1'b0;
        end else begin
            Tx_Busy <= (state != ST_IDLE);
            case (state)
                ST_START:  Tx <= 1'b0;
                ST_DATA:   Tx <= shreg[0];
                ST_PARITY: Tx <= par_bit;
`ifdef UART_TX_BREAK_EN
                ST_BREAK:  Tx <= break_rel;
`endif
                default:   Tx <= 1'b1;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// tb/tb_uart_tx_fifo.sv - directed self-checking bench for uart_tx_fifo (DIV=10, 8E1)
module tb_uart_tx_fifo;

    logic       SysClk = 1'b0;
    logic       Rst = 1'b1;
    logic [7:0] Tx_Data = 8'h00;
    logic       Write_En = 1'b0;
    logic       Overflow_Clr = 1'b0;
    logic       CTS = 1'b1;
`ifdef UART_TX_BREAK_EN
    logic       Break_Req = 1'b0;
`endif
    logic       Tx;
    logic       Tx_Busy;
    logic       FIFO_Empty;
    logic       FIFO_Full;
    logic       FIFO_Overflow;
    logic [3:0] Fill_Level;

    int n_asserts = 0;
    int n_fail = 0;

    uart_tx_fifo #(
        .SYSCLK_RATE (100000000),
        .BAUD_RATE   (10000000),
        .DATA_BITS   (8),
        .PARITY_MODE (2),
        .STOP_BITS   (1),
        .FIFO_DEPTH  (8)
    ) dut (
        .SysClk        (SysClk),
        .Rst           (Rst),
        .Tx_Data       (Tx_Data),
        .Write_En      (Write_En),
        .Overflow_Clr  (Overflow_Clr),
        .CTS           (CTS),
`ifdef UART_TX_BREAK_EN
        .Break_Req     (Break_Req),
`endif
        .Tx            (Tx),
        .Tx_Busy       (Tx_Busy),
        .FIFO_Empty    (FIFO_Empty),
        .FIFO_Full     (FIFO_Full),
        .FIFO_Overflow (FIFO_Overflow),
        .Fill_Level    (Fill_Level)
    );

    always #5 SysClk = ~SysClk;

    task automatic tick();
        @(posedge SysClk);
        #1;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_asserts++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Call just after the edge that pops the byte; walks the 110-cycle 8E1 frame.
    task automatic check_frame(input logic [7:0] d, input int drop_at);
        int  busy_cnt;
        int  slot;
        logic exp;
        busy_cnt = 0;
        for (int c = 0; c < 110; c++) begin
            tick();
            slot = c / 10;
            if (slot == 0)      exp = 1'b0;
            else if (slot <= 8) exp = d[slot-1];
            else if (slot == 9) exp = ^d;
            else                exp = 1'b1;
            check($sformatf("frame_%02h_c%0d_tx", d, c), Tx, exp);
            if (Tx_Busy) busy_cnt++;
            if (c + 1 == drop_at) CTS = 1'b0;
        end
        check($sformatf("frame_%02h_busy_cycles", d), busy_cnt, 110);
    endtask

    initial begin
        // reset state
        ticks(3);
        check("rst_tx", Tx, 1);
        check("rst_busy", Tx_Busy, 0);
        check("rst_empty", FIFO_Empty, 1);
        check("rst_full", FIFO_Full, 0);
        check("rst_ovf", FIFO_Overflow, 0);
        check("rst_level", Fill_Level, 0);
        Rst = 1'b0;
        ticks(3);

        // single 0xA5 frame and push/pop latency
        Tx_Data = 8'hA5; Write_En = 1'b1;
        tick();
        Write_En = 1'b0;
        check("a5_empty_after_push", FIFO_Empty, 0);
        check("a5_level_after_push", Fill_Level, 1);
        tick();
        check("a5_empty_after_pop", FIFO_Empty, 1);
        check("a5_tx_before_start", Tx, 1);
        check("a5_busy_before_start", Tx_Busy, 0);
        check_frame(8'hA5, -1);
        tick();
        check("a5_busy_end", Tx_Busy, 0);
        check("a5_tx_end", Tx, 1);

        // CTS low: fill, overflow, clear
        CTS = 1'b0;
        ticks(3);
        for (int i = 0; i < 9; i++) begin
            Tx_Data = 8'(i + 1); Write_En = 1'b1;
            tick();
            if (i == 6) begin
                check("fill7_level", Fill_Level, 7);
                check("fill7_full", FIFO_Full, 0);
            end
            if (i == 7) begin
                check("fill8_level", Fill_Level, 8);
                check("fill8_full", FIFO_Full, 1);
                check("fill8_ovf", FIFO_Overflow, 0);
            end
        end
        check("fill9_ovf", FIFO_Overflow, 1);
        check("fill9_level", Fill_Level, 8);
        Overflow_Clr = 1'b1;
        tick();
        check("ovf_drop_beats_clr", FIFO_Overflow, 1);
        Write_En = 1'b0;
        tick();
        Overflow_Clr = 1'b0;
        check("ovf_cleared", FIFO_Overflow, 0);
        check("cts_low_tx_idle", Tx, 1);
        check("cts_low_busy", Tx_Busy, 0);
        Rst = 1'b1;
        tick();
        Rst = 1'b0;
        check("flush_empty", FIFO_Empty, 1);
        check("flush_full", FIFO_Full, 0);
        check("flush_level", Fill_Level, 0);

        // back-to-back 0x00 / 0xFF
        CTS = 1'b1;
        ticks(3);
        Tx_Data = 8'h00; Write_En = 1'b1;
        tick();
        Tx_Data = 8'hFF;
        tick();
        Write_En = 1'b0;
        check("b2b_level", Fill_Level, 1);
        check_frame(8'h00, -1);
        check_frame(8'hFF, -1);
        tick();
        check("b2b_busy_end", Tx_Busy, 0);
        check("b2b_empty_end", FIFO_Empty, 1);

        // CTS gating at frame start, drop mid-frame
        CTS = 1'b0;
        ticks(3);
        Write_En = 1'b1;
        Tx_Data = 8'h11; tick();
        Tx_Data = 8'h22; tick();
        Tx_Data = 8'h33; tick();
        Write_En = 1'b0;
        check("cts_q_level", Fill_Level, 3);
        ticks(5);
        check("cts_q_tx", Tx, 1);
        CTS = 1'b1;
        tick(); check("cts_rise_t1", Tx, 1);
        tick(); check("cts_rise_t2", Tx, 1);
        tick(); check("cts_rise_t3", Tx, 1);
        check("cts_rise_level", Fill_Level, 2);
        check_frame(8'h11, 30);
        tick();
        check("cts_drop_busy", Tx_Busy, 0);
        check("cts_drop_tx", Tx, 1);
        ticks(20);
        check("cts_drop_hold_tx", Tx, 1);
        check("cts_drop_hold_level", Fill_Level, 2);
        CTS = 1'b1;
        tick(); check("cts_rise2_t1", Tx, 1);
        tick(); check("cts_rise2_t2", Tx, 1);
        tick(); check("cts_rise2_t3", Tx, 1);
        check_frame(8'h22, -1);
        check_frame(8'h33, -1);
        tick();
        check("cts_end_busy", Tx_Busy, 0);
        check("cts_end_empty", FIFO_Empty, 1);

        // reset during data bit 3 with 4 queued
        Tx_Data = 8'h00; Write_En = 1'b1;
        ticks(5);
        Write_En = 1'b0;
        ticks(41);
        check("midrst_pre_tx", Tx, 0);
        check("midrst_pre_busy", Tx_Busy, 1);
        check("midrst_pre_level", Fill_Level, 4);
        Rst = 1'b1;
        tick();
        Rst = 1'b0;
        check("midrst_tx", Tx, 1);
        check("midrst_busy", Tx_Busy, 0);
        check("midrst_empty", FIFO_Empty, 1);
        check("midrst_level", Fill_Level, 0);
        ticks(20);
        check("midrst_quiet_tx", Tx, 1);
        check("midrst_quiet_busy", Tx_Busy, 0);

`ifdef UART_TX_BREAK_EN
        // break: 50 low, 10 high, then queued frame
        Break_Req = 1'b1; Tx_Data = 8'h5A; Write_En = 1'b1;
        tick();
        Write_En = 1'b0;
        check("brk_first_tx", Tx, 1);
        for (int i = 0; i < 49; i++) begin
            tick();
            check($sformatf("brk_low_%0d", i), Tx, 0);
            check($sformatf("brk_busy_%0d", i), Tx_Busy, 1);
        end
        Break_Req = 1'b0;
        tick();
        check("brk_low_last", Tx, 0);
        for (int i = 0; i < 10; i++) begin
            tick();
            check($sformatf("brk_rel_%0d", i), Tx, 1);
        end
        check_frame(8'h5A, -1);
        tick();
        check("brk_end_busy", Tx_Busy, 0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end

endmodule
